// File: rtl/advanced_fifo_burst_reader_pkg.sv
// Shared constants and helpers for the FIFO burst reader: FSM state encoding
// and the burst-length clamp.
package advanced_fifo_burst_reader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // A requested length of zero still moves one word; anything above the FIFO depth is capped.
    function automatic logic [31:0] clamp_burst_len(input logic [31:0] req_len,
                                                    input logic [31:0] max_len);
        logic [31:0] len;
        if (req_len == 32'd0) begin
            len = 32'd1;
        end else if (req_len > max_len) begin
            len = max_len;
        end else begin
            len = req_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/advanced_fifo_burst_reader_timer.sv
// Saturating idle timer: counts every cycle it is not cleared and flags when it
// has reached TIMEOUT_CYCLES-1.
module burst_timeout_timer
    import advanced_fifo_burst_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_LOG2   = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic terminal_count
);

    localparam logic [TIMEOUT_LOG2-1:0] COUNT_ZERO = {TIMEOUT_LOG2{1'b0}};
    localparam logic [TIMEOUT_LOG2-1:0] COUNT_ONE  = TIMEOUT_LOG2'(32'd1);
    localparam logic [TIMEOUT_LOG2-1:0] COUNT_TC   = TIMEOUT_LOG2'(TIMEOUT_CYCLES - 32'd1);

    logic [TIMEOUT_LOG2-1:0] count_q;
    logic [TIMEOUT_LOG2-1:0] count_d;

    // Next count: clear wins, otherwise increment and hold at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = COUNT_ZERO;
        end else if (count_q != COUNT_TC) begin
            count_d = count_q + COUNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= COUNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_count = (count_q == COUNT_TC);

endmodule

// File: rtl/advanced_fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO in bursts onto a valid/ready stream,
// marking the last beat of each burst and flushing partial bursts on timeout.
module advanced_fifo_burst_reader
    import advanced_fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int DEPTH_LOG2     = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_LOG2   = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DEPTH_LOG2:0]   burst_length,
    output logic                  fifo_read_enable,
    input  logic [WIDTH-1:0]      fifo_read_data,
    input  logic                  fifo_empty,
    input  logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  stream_valid,
    output logic [WIDTH-1:0]      stream_data,
    output logic                  stream_last,
    input  logic                  stream_ready,
    output logic                  busy,
    output logic                  timeout_burst
);

    localparam int LEN_W = DEPTH_LOG2 + 1;
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(32'd1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [LEN_W-1:0]  remaining_q;
    logic [LEN_W-1:0]  remaining_d;
    logic              stream_valid_q;
    logic              stream_valid_d;
    logic [WIDTH-1:0]  stream_data_q;
    logic [WIDTH-1:0]  stream_data_d;
    logic              stream_last_q;
    logic              stream_last_d;
    logic              timeout_burst_q;
    logic              timeout_burst_d;

    logic [LEN_W-1:0]  eff_len_s;
    logic              out_free_s;
    logic              pop_s;
    logic              full_start_s;
    logic              timeout_start_s;
    logic              timer_clear_s;
    logic              timer_tc_s;

    assign eff_len_s  = LEN_W'(clamp_burst_len(32'(burst_length), 32'(DEPTH)));
    assign out_free_s = !stream_valid_q || stream_ready;

    // Popping is suppressed during reset so no FIFO word is lost to a dropped slice.
    assign pop_s = !reset && (state_q == ST_BURST) && !fifo_empty &&
                   (remaining_q != LEN_ZERO) && out_free_s;

    assign full_start_s    = (state_q == ST_IDLE) && enable && (fifo_level >= eff_len_s);
    assign timeout_start_s = (state_q == ST_IDLE) && enable && !fifo_empty &&
                             timer_tc_s && !full_start_s;
    assign timer_clear_s   = (state_q != ST_IDLE) || fifo_empty || !enable ||
                             full_start_s || timeout_start_s;

    burst_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_LOG2   (TIMEOUT_LOG2)
    ) u_timer (
        .clock          (clock),
        .reset          (reset),
        .clear          (timer_clear_s),
        .terminal_count (timer_tc_s)
    );

    // Burst sequencing: start decision in IDLE, beat countdown in BURST, hand-off wait in DRAIN.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        timeout_burst_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_start_s) begin
                    state_d     = ST_BURST;
                    remaining_d = eff_len_s;
                end else if (timeout_start_s) begin
                    state_d         = ST_BURST;
                    remaining_d     = fifo_level;
                    timeout_burst_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (pop_s) begin
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_DRAIN: begin
                if (out_free_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = LEN_ZERO;
            end
        endcase
    end

    // One-entry output slice: load on pop, empty on accept, otherwise hold.
    always_comb begin
        stream_valid_d = stream_valid_q;
        stream_data_d  = stream_data_q;
        stream_last_d  = stream_last_q;
        if (pop_s) begin
            stream_valid_d = 1'b1;
            stream_data_d  = fifo_read_data;
            stream_last_d  = (remaining_q == LEN_ONE);
        end else if (stream_ready) begin
            stream_valid_d = 1'b0;
            stream_last_d  = 1'b0;
        end else begin
            stream_valid_d = stream_valid_q;
            stream_last_d  = stream_last_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            remaining_q     <= LEN_ZERO;
            stream_valid_q  <= 1'b0;
            stream_data_q   <= {WIDTH{1'b0}};
            stream_last_q   <= 1'b0;
            timeout_burst_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            stream_valid_q  <= stream_valid_d;
            stream_data_q   <= stream_data_d;
            stream_last_q   <= stream_last_d;
            timeout_burst_q <= timeout_burst_d;
        end
    end

    assign fifo_read_enable = pop_s;
    assign stream_valid     = stream_valid_q;
    assign stream_data      = stream_data_q;
    assign stream_last      = stream_last_q;
    assign busy             = (state_q != ST_IDLE);
    assign timeout_burst    = timeout_burst_q;

endmodule

// File: doc/advanced_fifo_burst_reader.md
Name: advanced_fifo_burst_reader

Overview:
- Single-clock drain engine on the read side of an advanced FIFO.
- Pops the FIFO's first-word-fall-through read interface in fixed-length bursts and presents them as a valid/ready stream with a per-burst last marker.
- A burst starts when the FIFO level reaches the programmed burst length.
- If data sits below that length for too long, a shorter timeout burst flushes what is present.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 4, depth of the attached FIFO; maximum burst length.
- DEPTH_LOG2, CLOG2(DEPTH), FIFO address width; level ports are DEPTH_LOG2+1 bits.
- TIMEOUT_CYCLES, 16, idle cycles with non-empty FIFO before a partial burst is forced; minimum 2.
- TIMEOUT_LOG2, CLOG2(TIMEOUT_CYCLES), timeout counter width.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  allows new bursts to start; a burst in progress always completes.
- burst_length  input  DEPTH_LOG2+1  beats per full burst; sampled at burst start; 0 → 1, >DEPTH → DEPTH.
- fifo_read_enable  output  1  pop strobe to FIFO (combinational).
- fifo_read_data  input  WIDTH  FIFO head word, valid when fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_level  input  DEPTH_LOG2+1  FIFO occupancy.
- stream_valid  output  1  output beat valid (registered).
- stream_data  output  WIDTH  output beat data (registered).
- stream_last  output  1  marks the final beat of a burst (registered).
- stream_ready  input  1  downstream accept.
- busy  output  1  state != IDLE.
- timeout_burst  output  1  one-cycle pulse when a timeout burst starts.

Behaviour:
- Reset: state IDLE, remaining=0, timer=0. stream_valid, stream_data, stream_last, timeout_burst all 0. fifo_read_enable=0, busy=0. Any in-flight beat is dropped.
- eff_len = clamp(burst_length, 1, DEPTH), computed from the value at burst start.
- Output register: a one-entry slice. A pop loads fifo_read_data into stream_data and sets stream_valid on the next edge, so latency is 1 cycle from pop.
  - stream_valid, stream_data and stream_last hold stable while stream_valid=1 and stream_ready=0.
  - stream_valid clears on accept unless a new pop occurs in the same cycle.
- Pop rule: fifo_read_enable = (state==BURST) && !fifo_empty && remaining!=0 && (!stream_valid || stream_ready). This allows full throughput of 1 beat/cycle with back-to-back accept.
- IDLE:
  - timer clears when fifo_empty=1 or enable=0; otherwise it increments.
  - If enable && fifo_level >= eff_len: go to BURST with remaining=eff_len, timer=0.
  - Else if enable && !fifo_empty && timer==TIMEOUT_CYCLES-1: go to BURST with remaining=fifo_level, pulse timeout_burst, timer=0.
  - The full-burst condition has priority over timeout.
- BURST:
  - Each pop decrements remaining.
  - The pop with remaining==1 sets stream_last=1 on that beat and moves to DRAIN.
  - fifo_empty=1 during BURST stalls the burst (no pop, no error); the burst resumes when data arrives.
- DRAIN: go to IDLE when !stream_valid || stream_ready. The next burst cannot pop before the last beat is accepted.
- enable=0 during BURST or DRAIN has no effect; it only gates starts from IDLE.
- Arithmetic: remaining and level compares are unsigned, DEPTH_LOG2+1 bits. No wrap, because remaining never underflows under the pop rule.
- Writes to the FIFO may occur concurrently; only this block pops, so fifo_level can only rise relative to remaining during a burst.

Decomposition:
- Package advanced_fifo_burst_reader_pkg:
  - state encoding IDLE=0, BURST=1, DRAIN=2 (2-bit);
  - clamp helper function for eff_len.
- One sub-module, burst_timeout_timer: saturating counter with clear and terminal-count output, parameterised by TIMEOUT_CYCLES.
- The output slice stays inline.

Test Plan (DEPTH=4, WIDTH=8, TIMEOUT_CYCLES=16):
- burst_length=4, preload A0..A3, stream_ready=1 → pops on 4 consecutive cycles; stream_valid 1 cycle after first pop; data A0..A3; stream_last only on A3; busy drops after A3 accepted.
- burst_length=4, 2 words B0,B1, no more writes → no pop for 15 cycles; timeout_burst pulses at cycle 16; B0,B1 out with stream_last on B1.
- burst_length=2, 4 words, stream_ready toggling 1,0,0,1,… → data stable while ready=0; two bursts of 2 with last on beats 2 and 4; fifo_read_enable never asserted while stream_valid&&!stream_ready.
- burst_length=0 and burst_length=7 → behave as length 1 and length 4 respectively.
- Assert reset for 1 cycle mid-burst after 2 of 4 beats → all outputs 0 next cycle, state IDLE, remaining FIFO words restart as a new burst.
- enable=0 with FIFO full → no pops, timer held at 0; enable dropped mid-burst → burst finishes all 4 beats.
